// File: rtl/float_adder_arbiter.sv
// Round-robin arbiter sharing one float adder among NUM_REQ requesters.
// Optional FLOAT_ARB_STATS_EN adds per-requester saturating grant counters.
module float_adder_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_stb,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [31:0]            rsp_z,
    output logic [NUM_REQ-1:0]     rsp_stb,
    input  logic [NUM_REQ-1:0]     rsp_ack,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    output logic                   add_a_stb,
    output logic                   add_b_stb,
    input  logic                   add_a_ack,
    input  logic                   add_b_ack,
    input  logic [31:0]            add_z,
    input  logic                   add_z_stb,
    output logic                   add_z_ack,
`ifdef FLOAT_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]  grant_cnt,
`endif
    output logic                   busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = 1;
    localparam logic [GW:0] NREQ = (GW+1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_Z, RESP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [GW-1:0]  grant;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  pick;
    logic           pick_vld;
    logic [GW:0]    idx;
    logic           a_done;
    logic           b_done;
    logic           a_hit;
    logic           b_hit;

    assign a_hit = add_a_stb && add_a_ack;
    assign b_hit = add_b_stb && add_b_ack;

    // First pending requester at or after last_grant+1, wrapping
    always_comb begin
        pick     = last_grant;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = {1'b0, last_grant} + (GW+1)'(i);
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_stb[idx[GW-1:0]]) begin
                pick     = idx[GW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_vld) state_nxt = SEND;
            SEND:    if ((a_done || a_hit) && (b_done || b_hit))
                         state_nxt = WAIT_Z;
            WAIT_Z:  if (add_z_stb) state_nxt = RESP;
            RESP:    if (rsp_ack[grant]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, adder handshakes and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant      <= GW'(NUM_REQ-1);
            last_grant <= GW'(NUM_REQ-1);
            req_ack    <= '0;
            add_a      <= '0;
            add_b      <= '0;
            add_a_stb  <= 1'b0;
            add_b_stb  <= 1'b0;
            a_done     <= 1'b0;
            b_done     <= 1'b0;
            add_z_ack  <= 1'b0;
            rsp_z      <= '0;
        end else begin
            req_ack   <= '0;
            add_z_ack <= 1'b0;
            if (state == IDLE && pick_vld) begin
                grant     <= pick;
                add_a     <= req_a[32*pick +: 32];
                add_b     <= req_b[32*pick +: 32];
                req_ack   <= ONE << pick;
                add_a_stb <= 1'b1;
                add_b_stb <= 1'b1;
                a_done    <= 1'b0;
                b_done    <= 1'b0;
            end
            if (state == SEND) begin
                if (a_hit) begin
                    add_a_stb <= 1'b0;
                    a_done    <= 1'b1;
                end
                if (b_hit) begin
                    add_b_stb <= 1'b0;
                    b_done    <= 1'b1;
                end
            end
            if (state == WAIT_Z && add_z_stb) begin
                rsp_z     <= add_z;
                add_z_ack <= 1'b1;
            end
            if (state == RESP && rsp_ack[grant])
                last_grant <= grant;
        end
    end

    assign rsp_stb = (state == RESP) ? (ONE << grant) : '0;
    assign busy    = (state != IDLE);

`ifdef FLOAT_ARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    // Saturating count of grants per requester
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ack[i] && cnt[i] != 16'hFFFF)
                    cnt[i] <= cnt[i] + 16'd1;
        end
    end

    // Flatten counters onto the output bus
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++)
            grant_cnt[16*i +: 16] = cnt[i];
    end
`endif

endmodule

// File: doc/float_adder_arbiter.md
# float_adder_arbiter

Round-robin scheduler that shares one `apx_float_adder` (or accurate `adder`) instance between `NUM_REQ` requesters. Each requester presents an operand pair with a stb/ack handshake and receives its sum through a per-requester response handshake. The block sits between the requester logic and the adder. It drives the adder's `input_a`/`input_b`/`output_z` stb/ack protocol and serialises one transaction at a time.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `req_a`  input  NUM_REQ*32  operand A per requester; requester i uses `[32*i+31:32*i]`.
- `req_b`  input  NUM_REQ*32  operand B per requester, same packing.
- `req_stb`  input  NUM_REQ  operand pair valid; held until the matching `req_ack`.
- `req_ack`  output  NUM_REQ  one-cycle pulse when the operands are captured.
- `rsp_z`  output  32  result; shared by all requesters, valid while any `rsp_stb` bit is high.
- `rsp_stb`  output  NUM_REQ  result valid for requester g.
- `rsp_ack`  input  NUM_REQ  result consumed.
- `add_a`, `add_b`  output  32  to adder `input_a` / `input_b`.
- `add_a_stb`, `add_b_stb`  output  1  to adder strobes.
- `add_a_ack`, `add_b_ack`  input  1  from adder.
- `add_z`  input  32  from adder `output_z`.
- `add_z_stb`  input  1  from adder.
- `add_z_ack`  output  1  to adder `output_z_ack`.
- `busy`  output  1  high in every state except IDLE.

## Operation
- States are IDLE, SEND, WAIT_Z and RESP.
- **IDLE**
  - If any `req_stb` bit is high, select grant g: the first set bit searching upward from `last_grant+1`, wrapping at NUM_REQ.
  - Register `req_a[g]` and `req_b[g]`, pulse `req_ack[g]`, and go to SEND.
- **SEND**
  - `add_a_stb` and `add_b_stb` both rise on entry.
  - Each strobe falls independently on the cycle after its own ack is seen.
  - When both acks have been seen (in either order, or on the same cycle), go to WAIT_Z.
  - `add_a` and `add_b` hold the registered operands throughout.
- **WAIT_Z**
  - On `add_z_stb=1`, register `add_z` into `rsp_z`, pulse `add_z_ack` for exactly one cycle, and go to RESP.
- **RESP**
  - `rsp_stb[g]=1` until `rsp_ack[g]` is sampled high.
  - Then set `last_grant=g`, deassert `rsp_stb`, and return to IDLE.
  - `rsp_ack` bits other than g are ignored.
- The arbiter never interprets or modifies float bits; `rsp_z` is exactly the adder's `add_z`.
- Requests arriving while busy are held pending by their stb. The next grant is evaluated in the first IDLE cycle.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,…,NUM_REQ-1,0,…

## Timing
- Reset (asynchronous assert, synchronous release) gives:
  - state=IDLE and `last_grant=NUM_REQ-1`, so requester 0 wins first.
  - All `*_stb`, `*_ack`, `req_ack` and `busy` = 0.
  - `rsp_z`, `add_a` and `add_b` = 0.
- `req_stb` high in IDLE → `req_ack` registered high on the next edge: 1-cycle latency.
- Arbiter overhead excluding adder latency:
  - 1 cycle in IDLE.
  - ≥1 cycle per SEND handshake.
  - 1 cycle for the z capture.
  - ≥1 cycle in RESP.
- `rsp_ack` already high when `rsp_stb` rises → RESP lasts 1 cycle, and IDLE follows on the next edge.
- Dropping `req_stb` before `req_ack` is a protocol violation. The arbiter only samples `req_stb` in IDLE.
- Reset asserted mid-transaction aborts the transaction with no response. Bench resets the adder with the same reset.

## Configuration
- Macro: `FLOAT_ARB_STATS_EN`.
- **Defined**
  - Adds output `grant_cnt` of width NUM_REQ*16: per-requester 16-bit saturating counters.
  - Requester g's counter increments on each `req_ack[g]` pulse and saturates at 16'hFFFF.
  - Counters reset to 0.
- **Undefined:** the port and counters are absent. All other behaviour is identical.

## Test plan
- **Single transaction:** NUM_REQ=2, adder NAB=0. Requester 0 sends a=32'h3F800000, b=32'h40000000.
  - `req_ack[0]` 1 cycle after stb.
  - `rsp_stb[0]` with `rsp_z`=32'h40400000.
- **Simultaneous requests after reset:**
  - Req0: 3F800000+3F800000 → 40000000.
  - Req1: 40400000+3F800000 → 40800000.
  - Req0 must be served first and req1 second.
- **Round robin:** both requesters hold stb continuously for 6 transactions. Grant order must be 0,1,0,1,0,1, with no starvation.
- **Response back-pressure:** hold `rsp_ack` low for 20 cycles. `rsp_stb` and `rsp_z` must stay stable, `busy`=1, and no `req_ack` pulses in that window.
- **Reset mid-WAIT_Z:** assert `rst`=0 while waiting for the adder.
  - All outputs must be 0 immediately.
  - After release, a new request completes correctly.
- **Stats (`FLOAT_ARB_STATS_EN`):** after the round-robin test, `grant_cnt` must be {16'd3,16'd3}.
